// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for the EX stage: {remainder, quotient} in DATA_W iterations.
// Optional: define DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  // state  | meaning
  // FREE   | idle, waiting for an un-annulled start
  // BYZERO | divisor was zero, result forced to 0 on next edge
  // ON     | one restoring iteration per clock
  // END    | result held with ready until EX drops start
  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t                r_state;
  state_t                w_state_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_dvsr;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic [DATA_W-1:0]     w_a_mag;
  logic [DATA_W-1:0]     w_b_mag;
  logic                  w_b_zero;
  logic                  w_accept;
  logic                  w_early;
  logic                  w_cnt_last;
  logic [DATA_W:0]       w_rem_sh;
  logic                  w_ge;
  logic [DATA_W-1:0]     w_rem_sub;
  logic [DATA_W-1:0]     w_rem_nx;
  logic [DATA_W-1:0]     w_quo_nx;
  logic [DATA_W-1:0]     w_rem_fix;
  logic [DATA_W-1:0]     w_quo_fix;

  assign w_a_mag  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_b_mag  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign w_b_zero = (opdata2_i == '0);
  assign w_accept = start_i && !annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_b_zero && (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  assign w_cnt_last = (r_cnt == CNT_W'(DATA_W - 1));

  // Shifted partial remainder needs one extra bit before the compare.
  assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_dvsr;
  assign w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0];
  assign w_quo_nx  = {r_quo[DATA_W-2:0], w_ge};
  assign w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) begin
          if (w_b_zero)     w_state_nx = S_BYZERO;
          else if (w_early) w_state_nx = S_END;
          else              w_state_nx = S_ON;
        end
      end
      S_BYZERO: w_state_nx = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)         w_state_nx = S_FREE;
        else if (w_cnt_last) w_state_nx = S_END;
      end
      S_END:   if (annul_i || !start_i) w_state_nx = S_FREE;
      default: w_state_nx = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_FREE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvsr  <= w_b_mag;
            r_cnt   <= '0;
            r_neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_neg_r <= signed_div_i && opdata1_i[DATA_W-1];
            if (w_early) begin
              r_result <= {opdata1_i, {DATA_W{1'b0}}};
              r_ready  <= 1'b1;
            end
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state == S_ON) || (r_state == S_BYZERO);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed spec cases plus randomized divides against an arithmetic model.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] res;
  logic        rdy;
  logic        busy;

  int total = 0;
  int bad   = 0;

  div_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_div_i(sgn),
    .opdata1_i(a), .opdata2_i(b), .annul_i(annul),
    .result_o(res), .ready_o(rdy), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit integer division truncates toward zero, remainder follows dividend.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint ax, ay, q, r;
    if (y == 32'd0) return 64'd0;
    if (s) begin ax = $signed(x); ay = $signed(y); end
    else   begin ax = {32'd0, x}; ay = {32'd0, y}; end
    q = ax / ay;
    r = ax % ay;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint ax, ay;
    if (y == 32'd0) return 1;
    if (s) begin ax = $signed(x); ay = $signed(y); end
    else   begin ax = {32'd0, x}; ay = {32'd0, y}; end
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
`ifdef DIV_EARLY_OUT_EN
    if (ax < ay) return 0;
`endif
    return 32;
  endfunction

  // Drive a request, pass the accepting edge, then scramble the operand inputs.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    a = $urandom; b = $urandom; sgn = 1'($urandom);
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (rdy !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input int hold, output logic [63:0] got);
    int lat;
    logic [63:0] exp_r;
    int exp_l;
    exp_r = model(x, y, s);
    exp_l = model_lat(x, y, s);
    start_op(x, y, s);
    wait_ready(lat);
    got = res;
    total++;
    if (lat != exp_l) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_l); end
    total++;
    if (res !== exp_r) begin bad++; $display("FAIL %s result got=%h exp=%h", name, res, exp_r); end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (rdy !== 1'b1 || res !== exp_r) begin
        bad++; $display("FAIL %s hold ready=%b res=%h exp=%h", name, rdy, res, exp_r);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rdy !== 1'b0 || res !== 64'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s release ready=%b res=%h busy=%b exp 0", name, rdy, res, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (res !== 64'd0 || rdy !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset res=%h ready=%b busy=%b exp 0", res, rdy, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [63:0] got;
    run_op("u100_7", 32'd100, 32'd7, 1'b0, 4, got);
    total++;
    if (got !== {32'd2, 32'd14}) begin bad++; $display("FAIL u100_7_const got=%h exp=%h", got, {32'd2, 32'd14}); end
  endtask

  task automatic test_signed();
    logic [63:0] got;
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1, got);
    total++;
    if (got !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      bad++; $display("FAIL s_m7_2_const got=%h exp=%h", got, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, got);
    total++;
    if (got !== {32'd0, 32'h8000_0000}) begin
      bad++; $display("FAIL s_min_m1_const got=%h exp=%h", got, {32'd0, 32'h8000_0000});
    end
  endtask

  task automatic test_div_zero();
    start_op(32'd5, 32'd0, 1'b0);
    total++;
    if (busy !== 1'b1 || rdy !== 1'b0) begin bad++; $display("FAIL dz_byzero busy=%b ready=%b exp 1/0", busy, rdy); end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rdy !== 1'b1 || res !== 64'd0) begin
      bad++; $display("FAIL dz_end busy=%b ready=%b res=%h exp 0/1/0", busy, rdy, res);
    end
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL dz_release ready=%b exp 0", rdy); end
  endtask

  task automatic test_annul();
    int lat;
    int errs;
    start_op(32'd1000, 32'd7, 1'b0);
    errs = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy !== 1'b0 || busy !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL annul_run bad_cycles=%0d exp 0", errs); end
    annul = 1'b1; a = 32'd200; b = 32'd10; sgn = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin bad++; $display("FAIL annul_free busy=%b ready=%b exp 0/0", busy, rdy); end
    annul = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL annul_restart busy=%b exp 1", busy); end
    a = $urandom; b = $urandom;
    wait_ready(lat);
    total++;
    if (lat != 32 || res !== {32'd0, 32'd20}) begin
      bad++; $display("FAIL annul_200_10 lat=%0d res=%h exp 32 %h", lat, res, {32'd0, 32'd20});
    end
    // annul in END clears ready while start is still held
    annul = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rdy !== 1'b0 || res !== 64'd0) begin bad++; $display("FAIL annul_end ready=%b res=%h exp 0", rdy, res); end
    annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    // annul together with start in FREE drops the request
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
    errs = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || rdy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL annul_free_drop bad_cycles=%0d exp 0", errs); end
    start = 1'b0; annul = 1'b0;
    // annul in BYZERO produces no result
    start_op(32'd5, 32'd0, 1'b0);
    annul = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin bad++; $display("FAIL annul_byzero busy=%b ready=%b exp 0/0", busy, rdy); end
    annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    logic [63:0] got;
    start_op(32'd12345, 32'd17, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (res !== 64'd0 || rdy !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid res=%h ready=%b busy=%b exp 0", res, rdy, busy);
    end
    rst = 1'b0;
    run_op("rst_9_3", 32'd9, 32'd3, 1'b0, 0, got);
    total++;
    if (got !== {32'd0, 32'd3}) begin bad++; $display("FAIL rst_9_3_const got=%h exp=%h", got, {32'd0, 32'd3}); end
  endtask

  task automatic test_small();
    logic [63:0] got;
    run_op("u3_5", 32'd3, 32'd5, 1'b0, 2, got);
    total++;
    if (got !== {32'd3, 32'd0}) begin bad++; $display("FAIL u3_5_const got=%h exp=%h", got, {32'd3, 32'd0}); end
    run_op("s_m3_5", 32'hFFFF_FFFD, 32'd5, 1'b1, 0, got);
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    run_op("b2b_0", 32'd77, 32'd4, 1'b0, 0, got);
    run_op("b2b_1", 32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, 0, got);
    run_op("b2b_2", 32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b0, 0, got);
  endtask

  task automatic test_random();
    logic [63:0] got;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 50);
        2:       y = -$urandom_range(1, 50);
        default: y = $urandom;
      endcase
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
      run_op("random", x, y, 1'($urandom), $urandom_range(0, 2), got);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_rst_mid();
    test_small();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
